// File: rtl/piccolo_round_engine.sv
// Iterative Piccolo encryption datapath: one round per clock, whitening at load and
// after the last round. The round keys come from an external key schedule indexed by round.
module piccolo_round_engine #(
  parameter int ROUNDS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] din,
  input  logic [63:0] wk,
  input  logic [31:0] rk,
  output logic [4:0]  round,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  // Handshake: start is a request sampled only in IDLE (no ready; ignored while busy);
  // done is a one-cycle valid strobe for dout, which then holds until the next completion.

  function automatic logic [3:0] sbox(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'he;  4'h1: r = 4'h4;  4'h2: r = 4'hb;  4'h3: r = 4'h2;
      4'h4: r = 4'h3;  4'h5: r = 4'h8;  4'h6: r = 4'h0;  4'h7: r = 4'h9;
      4'h8: r = 4'h1;  4'h9: r = 4'ha;  4'ha: r = 4'h7;  4'hb: r = 4'hf;
      4'hc: r = 4'h6;  4'hd: r = 4'hc;  4'he: r = 4'h5;  default: r = 4'hd;
    endcase
    return r;
  endfunction

  // GF(2^4) doubling modulo x^4 + x + 1
  function automatic logic [3:0] mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] mul3(input logic [3:0] a);
    return mul2(a) ^ a;
  endfunction

  function automatic logic [15:0] f_func(input logic [15:0] v);
    logic [3:0] s0, s1, s2, s3;
    logic [3:0] y0, y1, y2, y3;
    s0 = sbox(v[15:12]);
    s1 = sbox(v[11:8]);
    s2 = sbox(v[7:4]);
    s3 = sbox(v[3:0]);
    y0 = mul2(s0) ^ mul3(s1) ^ s2 ^ s3;
    y1 = s0 ^ mul2(s1) ^ mul3(s2) ^ s3;
    y2 = s0 ^ s1 ^ mul2(s2) ^ mul3(s3);
    y3 = mul3(s0) ^ s1 ^ s2 ^ mul2(s3);
    return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
  endfunction

  state_t      state_q, state_d;
  logic [63:0] x_q, x_d;
  logic [15:0] wk2_q, wk2_d, wk3_q, wk3_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] dout_q, dout_d;
  logic        done_q, done_d;

  logic [63:0] y;
  logic [63:0] perm;

  always_comb begin
    y = {x_q[63:48], x_q[47:32] ^ f_func(x_q[63:48]) ^ rk[31:16],
         x_q[31:16], x_q[15:0]  ^ f_func(x_q[31:16]) ^ rk[15:0]};
    // bytes x0..x7 -> x2|x7|x4|x1|x6|x3|x0|x5
    perm = {y[47:40], y[7:0], y[31:24], y[55:48],
            y[15:8], y[39:32], y[63:56], y[23:16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      wk2_q   <= '0;
      wk3_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      wk2_q   <= wk2_d;
      wk3_q   <= wk3_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    wk2_d   = wk2_q;
    wk3_d   = wk3_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = {din[63:48] ^ wk[63:48], din[47:32], din[31:16] ^ wk[47:32], din[15:0]};
          wk2_d   = wk[31:16];
          wk3_d   = wk[15:0];
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          // final round: no permutation, output whitening instead
          state_d = IDLE;
          dout_d  = {y[63:48] ^ wk2_q, y[47:32], y[31:16] ^ wk3_q, y[15:0]};
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          x_d   = perm;
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign round     = busy ? cnt_q : 5'd0;
  assign done      = done_q;
  assign dout      = dout_q;
  assign dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_piccolo_round_engine.sv
// Directed bench for piccolo_round_engine: Piccolo-80 key schedule model, a reference
// encryption model, table-driven blocks and hand-written multi-cycle corner cases.
module tb_piccolo_round_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start31;
  logic [63:0] din, wk;
  logic [31:0] rk;
  logic [4:0]  round, round31;
  logic        busy, done, busy31, done31, dbg_state, dbg_state31;
  logic [63:0] dout, dout31;
  logic        use_key;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  logic [31:0] rk_tab[32];
  logic [63:0] key_wk;

  localparam logic [63:0] P0   = 64'h0123456789abcdef;
  localparam logic [63:0] C0   = 64'h8d2bff9935f84056;
  localparam logic [3:0]  SB[16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                     4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
  localparam logic [3:0]  MM[4][4] = '{'{4'd2, 4'd3, 4'd1, 4'd1}, '{4'd1, 4'd2, 4'd3, 4'd1},
                                       '{4'd1, 4'd1, 4'd2, 4'd3}, '{4'd3, 4'd1, 4'd1, 4'd2}};
  localparam int          RP[8] = '{2, 7, 4, 1, 6, 3, 0, 5};

  typedef struct {
    logic [63:0] din;
    logic [63:0] wk;
    bit          use_key;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  piccolo_round_engine #(.ROUNDS(25)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .wk(wk), .rk(rk),
    .round(round), .busy(busy), .done(done), .dout(dout), .dbg_state(dbg_state)
  );

  piccolo_round_engine #(.ROUNDS(31)) u_dut31 (
    .clk(clk), .rst_n(rst_n), .start(start31), .din(64'h0), .wk(64'h0), .rk(32'h0),
    .round(round31), .busy(busy31), .done(done31), .dout(dout31), .dbg_state(dbg_state31)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end required end");
    $fatal(1);
  end

  // external key schedule
  always_comb rk = use_key ? rk_tab[round] : 32'h0;

  // ---------------- reference model ----------------
  function automatic logic [3:0] gf_mul(input logic [3:0] a_in, input logic [3:0] b_in);
    logic [3:0] a, b, p;
    logic       c;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[0]) p = p ^ a;
      c = a[3];
      a = {a[2:0], 1'b0};
      if (c) a = a ^ 4'h3;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [15:0] m_f(input logic [15:0] v);
    logic [3:0] s[4];
    logic [3:0] o;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) s[i] = SB[v[15-4*i -: 4]];
    r = '0;
    for (int row = 0; row < 4; row++) begin
      o = '0;
      for (int col = 0; col < 4; col++) o = o ^ gf_mul(MM[row][col], s[col]);
      r[15-4*row -: 4] = SB[o];
    end
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] p, input logic [63:0] w,
                                        input bit key_on, input int nr);
    logic [15:0] x[4];
    logic [7:0]  b[8];
    logic [63:0] s, t;
    logic [31:0] k;
    x[0] = p[63:48] ^ w[63:48]; x[1] = p[47:32];
    x[2] = p[31:16] ^ w[47:32]; x[3] = p[15:0];
    for (int r = 0; r < nr; r++) begin
      k = key_on ? rk_tab[r] : 32'h0;
      x[1] = x[1] ^ m_f(x[0]) ^ k[31:16];
      x[3] = x[3] ^ m_f(x[2]) ^ k[15:0];
      if (r != nr - 1) begin
        s = {x[0], x[1], x[2], x[3]};
        for (int j = 0; j < 8; j++) b[j] = s[63-8*j -: 8];
        for (int j = 0; j < 8; j++) t[63-8*j -: 8] = b[RP[j]];
        x[0] = t[63:48]; x[1] = t[47:32]; x[2] = t[31:16]; x[3] = t[15:0];
      end
    end
    x[0] = x[0] ^ w[31:16];
    x[2] = x[2] ^ w[15:0];
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic key_schedule80(input logic [79:0] key);
    logic [15:0] k[5];
    logic [4:0]  c;
    logic [31:0] con;
    for (int i = 0; i < 5; i++) k[i] = key[79-16*i -: 16];
    key_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
              k[4][15:8], k[3][7:0], k[3][15:8], k[4][7:0]};
    for (int i = 0; i < 32; i++) rk_tab[i] = '0;
    for (int i = 0; i < 25; i++) begin
      c   = 5'(i + 1);
      con = {c, 5'b0, c, 2'b00, c, 5'b0, c} ^ 32'h0f1e2d3c;
      case (i % 5)
        0, 2:    rk_tab[i] = con ^ {k[2], k[3]};
        1, 4:    rk_tab[i] = con ^ {k[0], k[1]};
        default: rk_tab[i] = con ^ {k[4], k[4]};
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("unrequested_done", {63'b0, done}, 64'h0);
      else check("dout", dout, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_done(input bit trace, output int n);
    n = 1;
    if (trace) check("busy_after_start", {63'b0, busy}, 64'h1);
    while (done !== 1'b1 && n < 60) begin
      if (trace) check($sformatf("round_trace_%0d", n - 1), {59'b0, round}, 64'(n - 1));
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_block(input vec_t v, input bit trace);
    int n;
    @(posedge clk); #1;
    din = v.din; wk = v.wk; use_key = v.use_key; start = 1'b1;
    exp_q.push_back(v.exp);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(trace, n);
    check("latency", 64'(n), 64'd26);
    check("round_zero_at_done", {59'b0, round}, 64'h0);
    check("busy_low_at_done", {63'b0, busy}, 64'h0);
  endtask

  initial begin
    int n;
    vec_t v;
    rst_n = 1'b0; start = 1'b0; start31 = 1'b0; din = '0; wk = '0; use_key = 1'b0;
    key_schedule80(80'h00112233445566778899);

    vecs[0] = '{din: P0,                  wk: key_wk, use_key: 1'b1, exp: C0};
    vecs[1] = '{din: 64'h0,               wk: 64'h0,  use_key: 1'b0, exp: model(64'h0, 64'h0, 1'b0, 25)};
    vecs[2] = '{din: 64'hffffffffffffffff, wk: key_wk, use_key: 1'b1,
                exp: model(64'hffffffffffffffff, key_wk, 1'b1, 25)};
    vecs[3] = '{din: 64'h1122334455667788, wk: 64'h0f0f00ffa5a5c3c3, use_key: 1'b1,
                exp: model(64'h1122334455667788, 64'h0f0f00ffa5a5c3c3, 1'b1, 25)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, busy}, 64'h0);
    check("reset_done", {63'b0, done}, 64'h0);
    check("reset_round", {59'b0, round}, 64'h0);
    check("reset_dout", dout, 64'h0);
    check("reset_state", {63'b0, dbg_state}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven blocks; first one also traces the round index
    for (int i = 0; i < 4; i++) run_block(vecs[i], i == 0);

    // start held high: a block completes every 26 cycles, busy drops only on done
    @(posedge clk); #1;
    din = P0; wk = key_wk; use_key = 1'b1; start = 1'b1;
    repeat (3) exp_q.push_back(C0);
    for (int c = 1; c <= 78; c++) begin
      @(posedge clk); #1;
      check($sformatf("held_done_c%0d", c), {63'b0, done}, {63'b0, (c % 26) == 0});
      check($sformatf("held_busy_c%0d", c), {63'b0, busy}, {63'b0, (c % 26) != 0});
    end
    start = 1'b0;

    // start and input changes during RUN are ignored
    @(posedge clk); #1;
    din = P0; wk = key_wk; start = 1'b1;
    exp_q.push_back(C0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      if (round == 5'd10) begin
        start = 1'b1;
        din = 64'hdeadbeefcafef00d;
      end else if (round == 5'd11) begin
        start = 1'b0;
      end
      wk  = {$urandom, $urandom};
      din = din ^ {$urandom, $urandom};
      @(posedge clk); #1;
      n++;
    end
    check("ignore_latency", 64'(n), 64'd26);
    repeat (30) @(posedge clk);
    #1;
    check("ignore_no_extra_run", {63'b0, busy}, 64'h0);

    // asynchronous reset during round 12
    @(posedge clk); #1;
    din = P0; wk = key_wk; start = 1'b1;
    exp_q.push_back(C0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (round != 5'd12 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_round12", {59'b0, round}, 64'd12);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", {63'b0, busy}, 64'h0);
    check("midrun_reset_done", {63'b0, done}, 64'h0);
    check("midrun_reset_round", {59'b0, round}, 64'h0);
    check("midrun_reset_dout", dout, 64'h0);
    check("midrun_reset_state", {63'b0, dbg_state}, 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; din = P0; wk = key_wk;
    exp_q.push_back(C0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, n);
    check("post_reset_latency", 64'(n), 64'd26);

    // Piccolo-128 round count, all-zero data and keys
    @(posedge clk); #1;
    start31 = 1'b1;
    @(posedge clk); #1;
    start31 = 1'b0;
    check("r31_busy", {63'b0, busy31}, 64'h1);
    n = 1;
    while (done31 !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("r31_latency", 64'(n), 64'd32);
    check("r31_dout", dout31, model(64'h0, 64'h0, 1'b0, 31));
    @(posedge clk); #1;
    check("r31_done_pulse", {63'b0, done31}, 64'h0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
